drive_bus_phase_gen: RTL and testbench
======================================

Name: drive_bus_phase_gen

Overview:
Parametrised front end for the disk-drive logic blocks. It combines a per-channel serial-bus input synchroniser/deglitcher with a CPU/VIA phase-enable generator. Successor to the fixed 3-line, 2-flop filter and fixed ÷32 phase divider. Adds:
- configurable channel count and filter depth;
- edge pulses;
- a glitch-free runtime switch between slow (1 MHz, 1541) and fast (2 MHz, 1571) phase rates.

Parameters:
CHANNELS, 3, number of bus input lines filtered (e.g. ATN, DATA, CLK).
SYNC_STAGES, 2, metastability flops per channel, minimum 2.
FILTER_CNT, 1, consecutive stable cycles beyond sync before the filtered output changes, minimum 1.
RESET_VAL, 1'b1, reset value of every filtered output (bus idle, released).
DIV_SLOW, 32, clk32 cycles per phase period in slow mode; even, minimum 4.
DIV_FAST, 16, clk32 cycles per phase period in fast mode; even, minimum 4, at most DIV_SLOW.

Ports:
clk32  in  1  system clock (32 MHz nominal).
reset  in  1  synchronous, active-high reset.
bus_in  in  CHANNELS  raw asynchronous bus lines.
bus_out  out  CHANNELS  synchronised, deglitched lines.
bus_rise  out  CHANNELS  one-cycle pulse when bus_out goes 0→1.
bus_fall  out  CHANNELS  one-cycle pulse when bus_out goes 1→0.
fast_req  in  1  requested mode: 1 = fast, 0 = slow.
fast_act  out  1  mode currently in effect.
pause  in  1  freeze request (effective only with DRIVE_PAUSE_EN).
p2_h_r  out  1  one-cycle phase-2 rising enable.
p2_h_f  out  1  one-cycle phase-2 falling enable; this is the CPU step enable.

Behaviour:
- Reset (synchronous, active-high):
  - sync flops and bus_out are set to RESET_VAL; filter counters cleared.
  - bus_rise, bus_fall, p2_h_r, p2_h_f are 0; fast_act is 0; divider is 0.
- Per-channel filter:
  - s is the output of the last sync flop.
  - If s == bus_out, the counter clears.
  - Otherwise the counter increments. When it reaches FILTER_CNT, bus_out takes s on the next edge and the counter clears.
  - Latency from an input change to bus_out is SYNC_STAGES+FILTER_CNT cycles; default is 3.
  - A glitch shorter than FILTER_CNT cycles, measured at s, never reaches bus_out.
- Edge pulses are registered and asserted in the same cycle bus_out changes, for exactly one cycle. Channels are fully independent; simultaneous edges on several channels all pulse.
- Divider:
  - D = DIV_FAST when fast_act = 1, else DIV_SLOW.
  - div counts 0..D-1 and then wraps to 0.
  - p2_h_r is registered (div == 0); p2_h_f is registered (div == D/2).
  - Both pulses are one cycle wide, never coincide, and each repeats every D cycles.
- Mode switch:
  - fast_req is sampled only in the cycle where div == D-1.
  - In that cycle fast_act loads fast_req and div wraps to 0, so every phase period is a complete old-mode or new-mode period; no short or long phase is ever produced.
  - A fast_req toggle within a period that returns before the wrap has no effect.
- Reset mid-operation clears everything on the same edge, including a pending mode change.
- First p2_h_r after reset deassertion: the 2nd cycle (div == 0 in cycle 1, pulse registered in cycle 2). The first p2_h_f follows D/2 cycles later.

Optional Feature:
Macro DRIVE_PAUSE_EN.
- Defined:
  - If pause == 1 when div == D-1, div wraps to 0 and then holds at 0. No p2_h_r or p2_h_f is generated while held, and the mode does not change.
  - When pause returns to 0, counting resumes: div → 1 on the next edge. p2_h_r fires on the first resume cycle (registered from the held 0 state), so exactly one p2_h_r occurs per resumed period.
  - pause asserted mid-period takes effect only at the next wrap.
  - The filter path is unaffected by pause.
- Undefined: the pause port exists but is ignored; behaviour is identical to pause = 0.

Decomposition:
- Shared package drive_pkg holds:
  - constants DRV_DIV_1MHZ = 32 and DRV_DIV_2MHZ = 16;
  - channel index constants IEC_ATN = 0, IEC_DATA = 1, IEC_CLK = 2;
  - a width helper for the divider counter, clog2(DIV_SLOW).
- One natural sub-module: drive_bus_filter, a single-channel sync, deglitch and edge block instantiated CHANNELS times by a generate loop.
- The divider stays in the top module.

Test Plan:
1. Reset held 4 cycles then released, fast_req = 0 → bus_out = 3'b111; p2_h_r in cycle 2, p2_h_f in cycle 18, p2_h_r again in cycle 34; period 32.
2. bus_in[1] 1→0 held → bus_out[1] = 0 exactly 3 cycles later; bus_fall[1] = 1 in that same cycle only; other channels show no pulses.
3. FILTER_CNT = 3, 2-cycle low glitch on bus_in[0] → bus_out[0] stays 1 and no pulse; a 3-cycle low pulse passes after 5 cycles.
4. fast_req 0→1 at div = 5 → slow period completes (32 cycles); fast_act rises at the wrap; subsequent p2_h_r spacing is 16. The reverse switch gives spacing 32 with no intermediate spacing.
5. Reset asserted at div = 20 with a mode switch pending → next cycle all pulses 0, fast_act = 0, div restarts; the first p2_h_r is the 2nd cycle after release.
6. DRIVE_PAUSE_EN defined, pause = 1 at div = 9 for 100 cycles → pulses stop after the wrap; on release p2_h_r in the next cycle, p2_h_f D/2 cycles later.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared constants for the drive front end: phase divider presets, IEC bus channel indices
// and a counter-width helper.
package drive_pkg;

   localparam int DRV_DIV_1MHZ = 32;
   localparam int DRV_DIV_2MHZ = 16;

   localparam int IEC_ATN  = 0;
   localparam int IEC_DATA = 1;
   localparam int IEC_CLK  = 2;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int drv_cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/drive_bus_filter.sv
// Single bus line: SYNC_STAGES-flop synchroniser, FILTER_CNT-cycle deglitcher, registered edge pulses.
// Latency SYNC_STAGES+FILTER_CNT cycles from pin to dout; free-running, no backpressure.
module drive_bus_filter
   import drive_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER_CNT  = 1,
   parameter logic RESET_VAL   = 1'b1
) (
   input  logic clk32,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam int            CW       = drv_cnt_width(FILTER_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   s;
   logic                   settle;

   assign s = sync[SYNC_STAGES-1];

   // The line has differed from dout for FILTER_CNT consecutive samples, this one included.
   assign settle = (s != dout) && (cnt == CNT_LAST);

   always_ff @(posedge clk32) begin
      if (reset) begin
         sync <= {SYNC_STAGES{RESET_VAL}};
         cnt  <= '0;
         dout <= RESET_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         rise <= settle & s;
         fall <= settle & ~s;
         if (s == dout || settle)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (settle)
            dout <= s;
      end
   end

endmodule

// File: rtl/drive_bus_phase_gen.sv
// Drive front end: per-channel bus filters plus phase-2 enable generator with glitch-free 1/2 MHz switch.
// Filter latency SYNC_STAGES+FILTER_CNT, phase pulses registered; no backpressure. Option DRIVE_PAUSE_EN.
module drive_bus_phase_gen
   import drive_pkg::*;
#(
   parameter int   CHANNELS    = 3,
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER_CNT  = 1,
   parameter logic RESET_VAL   = 1'b1,
   parameter int   DIV_SLOW    = DRV_DIV_1MHZ,
   parameter int   DIV_FAST    = DRV_DIV_2MHZ
) (
   input  logic                clk32,
   input  logic                reset,
   input  logic [CHANNELS-1:0] bus_in,
   output logic [CHANNELS-1:0] bus_out,
   output logic [CHANNELS-1:0] bus_rise,
   output logic [CHANNELS-1:0] bus_fall,
   input  logic                fast_req,
   output logic                fast_act,
   input  logic                pause,
   output logic                p2_h_r,
   output logic                p2_h_f
);

   localparam int            DW        = drv_cnt_width(DIV_SLOW);
   localparam logic [DW-1:0] SLOW_LAST = DW'(DIV_SLOW - 1);
   localparam logic [DW-1:0] FAST_LAST = DW'(DIV_FAST - 1);
   localparam logic [DW-1:0] SLOW_HALF = DW'(DIV_SLOW / 2);
   localparam logic [DW-1:0] FAST_HALF = DW'(DIV_FAST / 2);

   if (SYNC_STAGES < 2 || FILTER_CNT < 1 || DIV_FAST < 4 || DIV_FAST > DIV_SLOW ||
       (DIV_SLOW % 2) != 0 || (DIV_FAST % 2) != 0) begin : g_bad_params
      $error("drive_bus_phase_gen: illegal parameter set");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      drive_bus_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_CNT  (FILTER_CNT),
         .RESET_VAL   (RESET_VAL)
      ) u_filt (
         .clk32 (clk32),
         .reset (reset),
         .din   (bus_in[i]),
         .dout  (bus_out[i]),
         .rise  (bus_rise[i]),
         .fall  (bus_fall[i])
      );
   end

   logic [DW-1:0] div;
   logic [DW-1:0] div_last;
   logic [DW-1:0] div_half;
   logic          wrap;
   logic          hold_now;
   logic          pause_eff;

   assign div_last = fast_act ? FAST_LAST : SLOW_LAST;
   assign div_half = fast_act ? FAST_HALF : SLOW_HALF;
   assign wrap     = (div == div_last);

`ifdef DRIVE_PAUSE_EN
   // Frozen at div 0 between periods; releasing lets the held 0 produce the period's p2_h_r.
   logic held;
   assign pause_eff = pause;
   assign hold_now  = held & pause;

   always_ff @(posedge clk32) begin
      if (reset)
         held <= 1'b0;
      else
         held <= (held | wrap) & pause;
   end
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign pause_eff    = 1'b0;
   assign hold_now     = 1'b0;
`endif

   // Mode only changes at the wrap, so every period is a whole old- or new-mode period.
   always_ff @(posedge clk32) begin
      if (reset) begin
         div      <= '0;
         fast_act <= 1'b0;
         p2_h_r   <= 1'b0;
         p2_h_f   <= 1'b0;
      end else begin
         p2_h_r <= (div == '0) & ~hold_now;
         p2_h_f <= (div == div_half);
         if (hold_now || wrap)
            div <= '0;
         else
            div <= div + DW'(1);
         if (wrap && !pause_eff)
            fast_act <= fast_req;
      end
   end

endmodule

// File: tb/tb_drive_bus_phase_gen.sv
// Bench for drive_bus_phase_gen: directed scenarios plus randomized run against a period/window model.
// Two instances share all inputs: default filter and FILTER_CNT=3.
module tb_drive_bus_phase_gen;
   import drive_pkg::*;

`ifdef DRIVE_PAUSE_EN
   localparam bit PAUSE_BUILD = 1'b1;
`else
   localparam bit PAUSE_BUILD = 1'b0;
`endif

   logic       clk32 = 1'b0;
   logic       reset = 1'b1;
   logic       fast_req = 1'b0;
   logic       pause = 1'b0;
   logic [2:0] bus_in = 3'b000;

   logic [2:0] a_out, a_rise, a_fall, b_out, b_rise, b_fall;
   logic       a_fa, a_r, a_f, b_fa, b_r, b_f;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk32 = ~clk32;

   drive_bus_phase_gen dut_a (
      .clk32 (clk32), .reset (reset), .bus_in (bus_in),
      .bus_out (a_out), .bus_rise (a_rise), .bus_fall (a_fall),
      .fast_req (fast_req), .fast_act (a_fa), .pause (pause),
      .p2_h_r (a_r), .p2_h_f (a_f)
   );

   drive_bus_phase_gen #(.FILTER_CNT (3)) dut_b (
      .clk32 (clk32), .reset (reset), .bus_in (bus_in),
      .bus_out (b_out), .bus_rise (b_rise), .bus_fall (b_fall),
      .fast_req (fast_req), .fast_act (b_fa), .pause (pause),
      .p2_h_r (b_r), .p2_h_f (b_f)
   );

   // Reference model. Divider: each period has a start cycle (div 0) and a length; the mode
   // for the next period is fast_req seen in the period's last cycle. Filter: output flips
   // once the last N synchronised samples all disagree with it.
   int         m_t, m_start, m_len;
   logic       m_fa, m_hold;
   logic [2:0] in_hist[$];
   logic [2:0] s_hist[$];
   logic [2:0] ma_out, ma_rise, ma_fall, mb_out, mb_rise, mb_fall;

   function automatic bit s_window_diff(input int n, input int b, input logic cur);
      if (s_hist.size() < n) return 1'b0;
      for (int i = 0; i < n; i++)
         if (s_hist[s_hist.size()-1-i][b] == cur) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk32) begin : p_model
      logic [2:0] s;
      logic       pz;
      pz = pause & PAUSE_BUILD;
      if (reset) begin
         m_t = 0; m_start = 0; m_len = DRV_DIV_1MHZ; m_fa = 1'b0; m_hold = 1'b0;
         in_hist.delete(); s_hist.delete();
         ma_out = 3'b111; ma_rise = '0; ma_fall = '0;
         mb_out = 3'b111; mb_rise = '0; mb_fall = '0;
      end else begin
         if (m_hold) begin
            if (!pz) begin m_hold = 1'b0; m_start = m_t; end
            else m_start = m_t + 1;
         end else if (m_t == m_start + m_len - 1) begin
            m_start = m_t + 1;
            if (pz) m_hold = 1'b1;
            else begin
               m_fa  = fast_req;
               m_len = fast_req ? DRV_DIV_2MHZ : DRV_DIV_1MHZ;
            end
         end
         m_t++;
         s = (in_hist.size() >= 2) ? in_hist[in_hist.size()-2] : 3'b111;
         s_hist.push_back(s);
         in_hist.push_back(bus_in);
         if (s_hist.size() > 8) void'(s_hist.pop_front());
         if (in_hist.size() > 8) void'(in_hist.pop_front());
         for (int b = 0; b < 3; b++) begin
            ma_rise[b] = 1'b0; ma_fall[b] = 1'b0; mb_rise[b] = 1'b0; mb_fall[b] = 1'b0;
            if (s_window_diff(1, b, ma_out[b])) begin
               ma_out[b] = ~ma_out[b]; ma_rise[b] = ma_out[b]; ma_fall[b] = ~ma_out[b];
            end
            if (s_window_diff(3, b, mb_out[b])) begin
               mb_out[b] = ~mb_out[b]; mb_rise[b] = mb_out[b]; mb_fall[b] = ~mb_out[b];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk32);
      #1;
   endtask

   task automatic test_reset();
      logic exp_r, exp_f;
      tick();
      @(negedge clk32);
      n_checks++;
      if ({a_out, a_rise, a_fall, a_fa, a_r, a_f} !== {3'b111, 6'b0, 3'b0}) begin
         n_fail++;
         $display("FAIL reset_state_a: got %b want %b", {a_out, a_rise, a_fall, a_fa, a_r, a_f}, {3'b111, 9'b0});
      end
      n_checks++;
      if ({b_out, b_rise, b_fall, b_fa, b_r, b_f} !== {3'b111, 6'b0, 3'b0}) begin
         n_fail++;
         $display("FAIL reset_state_b: got %b want %b", {b_out, b_rise, b_fall, b_fa, b_r, b_f}, {3'b111, 9'b0});
      end
      tick(); tick(); tick();
      reset  = 1'b0;
      bus_in = 3'b111;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk32);
         exp_r = (c == 2 || c == 34);
         exp_f = (c == 18);
         n_checks++;
         if ({a_out, a_fa, a_r, a_f} !== {3'b111, 1'b0, exp_r, exp_f}) begin
            n_fail++;
            $display("FAIL reset_first_phase c%0d: got out/fa/r/f %b want %b", c,
                     {a_out, a_fa, a_r, a_f}, {3'b111, 1'b0, exp_r, exp_f});
         end
         tick();
      end
   endtask

   task automatic test_fall_edge();
      bus_in[IEC_DATA] = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk32);
         n_checks++;
         if ({a_out[IEC_DATA], a_fall, a_rise} !== {(k < 3), (k == 3) ? 3'b010 : 3'b000, 3'b000}) begin
            n_fail++;
            $display("FAIL data_fall k%0d: got out1/fall/rise %b want %b", k, {a_out[IEC_DATA], a_fall, a_rise},
                     {(k < 3), (k == 3) ? 3'b010 : 3'b000, 3'b000});
         end
         tick();
      end
      bus_in = 3'b111;
      repeat (8) tick();
   endtask

   task automatic test_glitch();
      bus_in[IEC_ATN] = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         if (k == 2) bus_in[IEC_ATN] = 1'b1;
         @(negedge clk32);
         n_checks++;
         if ({b_out[IEC_ATN], b_rise[IEC_ATN], b_fall[IEC_ATN]} !== 3'b100) begin
            n_fail++;
            $display("FAIL glitch_blocked k%0d: got out/rise/fall %b want 100", k,
                     {b_out[IEC_ATN], b_rise[IEC_ATN], b_fall[IEC_ATN]});
         end
         tick();
      end
      bus_in[IEC_ATN] = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         if (k == 3) bus_in[IEC_ATN] = 1'b1;
         @(negedge clk32);
         n_checks++;
         if ({b_out[IEC_ATN], b_fall[IEC_ATN], b_rise[IEC_ATN]} !== {!(k >= 5 && k < 8), (k == 5), (k == 8)}) begin
            n_fail++;
            $display("FAIL pulse_passes k%0d: got out/fall/rise %b want %b", k,
                     {b_out[IEC_ATN], b_fall[IEC_ATN], b_rise[IEC_ATN]}, {!(k >= 5 && k < 8), (k == 5), (k == 8)});
         end
         tick();
      end
   endtask

   task automatic test_mode_switch();
      logic exp_r, exp_f, exp_fa;
      bit   found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (m_t - m_start == 5 && !m_hold && m_len == DRV_DIV_1MHZ) begin found = 1'b1; break; end
         tick();
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL mode_align: got no div 5 want div 5 within 80 cycles"); end
      // o counts cycles from the current period's p2_h_r (div 1); we start at div 5.
      for (int o = 4; o <= 120; o++) begin
         if (o == 4)  fast_req = 1'b1;
         if (o == 50) fast_req = 1'b0;
         if (o == 52) fast_req = 1'b1;
         if (o == 66) fast_req = 1'b0;
         @(negedge clk32);
         exp_r  = (o == 32 || o == 48 || o == 64 || o == 80 || o == 112);
         exp_f  = (o == 16 || o == 40 || o == 56 || o == 72 || o == 96);
         exp_fa = (o >= 31 && o <= 78);
         n_checks++;
         if ({a_r, a_f, a_fa} !== {exp_r, exp_f, exp_fa}) begin
            n_fail++;
            $display("FAIL mode_switch o%0d: got r/f/fa %b want %b", o, {a_r, a_f, a_fa}, {exp_r, exp_f, exp_fa});
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic exp_r, exp_f, exp_fa;
      bit   found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (m_t - m_start == 3 && !m_hold) begin found = 1'b1; break; end
         tick();
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL reset_mid_align: got no div 3 want div 3 within 80 cycles"); end
      fast_req = 1'b1;
      repeat (17) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 55; c++) begin
         @(negedge clk32);
         exp_r  = (c == 2 || c == 34 || c == 50);
         exp_f  = (c == 18 || c == 42);
         exp_fa = (c >= 33);
         n_checks++;
         if ({a_out, a_rise, a_fall, a_r, a_f, a_fa} !== {3'b111, 6'b0, exp_r, exp_f, exp_fa}) begin
            n_fail++;
            $display("FAIL reset_mid c%0d: got %b want %b", c, {a_out, a_rise, a_fall, a_r, a_f, a_fa},
                     {3'b111, 6'b0, exp_r, exp_f, exp_fa});
         end
         tick();
      end
   endtask

   task automatic test_pause();
      logic exp_r, exp_f;
      int   d = DRV_DIV_2MHZ;
      bit   found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (m_t - m_start == 9 && !m_hold && m_len == DRV_DIV_2MHZ) begin found = 1'b1; break; end
         tick();
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL pause_align: got no fast div 9 want fast div 9 within 80 cycles"); end
      for (int o = 8; o <= 126; o++) begin
         if (o == 8)   pause = 1'b1;
         if (o == 108) pause = 1'b0;
         @(negedge clk32);
         exp_r = PAUSE_BUILD ? (o == 109 || o == 109 + d) : (o % d == 0);
         exp_f = PAUSE_BUILD ? (o == d / 2 || o == 109 + d / 2) : (o % d == d / 2);
         n_checks++;
         if ({a_r, a_f, a_fa, b_r, b_f} !== {exp_r, exp_f, 1'b1, exp_r, exp_f}) begin
            n_fail++;
            $display("FAIL pause o%0d: got r/f/fa/br/bf %b want %b", o, {a_r, a_f, a_fa, b_r, b_f},
                     {exp_r, exp_f, 1'b1, exp_r, exp_f});
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic exp_r, exp_f;
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 3) == 0) bus_in[b] = ~bus_in[b];
         if ($urandom_range(0, 39) == 0) fast_req = ~fast_req;
         if ($urandom_range(0, 59) == 0) pause = ~pause;
         reset = ($urandom_range(0, 399) == 0);
         @(negedge clk32);
         exp_r = (m_t == m_start + 1);
         exp_f = (m_t == m_start + 1 + m_len / 2);
         n_checks++;
         if ({a_out, a_rise, a_fall} !== {ma_out, ma_rise, ma_fall}) begin
            n_fail++;
            $display("FAIL rand_filter_a i%0d: got %b want %b", i, {a_out, a_rise, a_fall}, {ma_out, ma_rise, ma_fall});
         end
         n_checks++;
         if ({b_out, b_rise, b_fall} !== {mb_out, mb_rise, mb_fall}) begin
            n_fail++;
            $display("FAIL rand_filter_b i%0d: got %b want %b", i, {b_out, b_rise, b_fall}, {mb_out, mb_rise, mb_fall});
         end
         n_checks++;
         if ({a_r, a_f, a_fa, b_r, b_f, b_fa} !== {exp_r, exp_f, m_fa, exp_r, exp_f, m_fa}) begin
            n_fail++;
            $display("FAIL rand_phase i%0d: got %b want %b", i, {a_r, a_f, a_fa, b_r, b_f, b_fa},
                     {exp_r, exp_f, m_fa, exp_r, exp_f, m_fa});
         end
         tick();
      end
      reset = 1'b0;
      pause = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion want completion before 400000 time units");
      $fatal(1, "bench timed out");
   end

   initial begin
      test_reset();
      test_fall_edge();
      test_glitch();
      test_mode_switch();
      test_reset_mid();
      test_pause();
      fast_req = 1'b0;
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
